// File: rtl/seq_detector_param.sv
// Parametrised serial pattern detector with KMP-style fallback, Mealy and
// Moore match flags, overlap/non-overlap modes and a saturating match counter.
module seq_detector_param #(
  parameter int                   PATTERN_W = 4,
  parameter logic [PATTERN_W-1:0] PATTERN   = 4'b1011,
  parameter bit                   OVERLAP   = 1'b1,
  parameter int                   CNT_W     = 8
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         clear,
  input  logic                         din,
  input  logic                         din_valid,
  output logic                         match,
  output logic                         match_q,
  output logic [CNT_W-1:0]             match_count,
  output logic [$clog2(PATTERN_W)-1:0] state_o
);

  localparam int SW = $clog2(PATTERN_W);
  localparam bit POW2 = ((1 << SW) == PATTERN_W);
  localparam logic [SW-1:0] LAST = SW'(PATTERN_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef logic [SW-1:0] state_t;
  typedef logic [2*PATTERN_W-1:0][SW-1:0] table_t;

  // Longest proper suffix of (prefix_k, b) that is also a pattern prefix;
  // the completed-pattern case yields f(PATTERN_W) or 0 in non-overlap mode.
  function automatic state_t next_k_f(input int k, input logic b);
    logic [PATTERN_W:0] s;
    state_t             best;
    logic               eq;
    s    = '0;
    best = '0;
    for (int i = 0; i < PATTERN_W; i++) begin
      if (i < k) s[i] = PATTERN[PATTERN_W-1-i];
      else       s[i] = 1'b0;
    end
    s[k] = b;
    for (int l = 1; l < PATTERN_W; l++) begin
      if (l <= k + 1) begin
        eq = 1'b1;
        for (int j = 0; j < PATTERN_W; j++) begin
          if (j < l) begin
            if (s[k+1-l+j] != PATTERN[PATTERN_W-1-j]) eq = 1'b0;
          end
        end
        if (eq) best = state_t'(l);
      end
    end
    if (!OVERLAP && (k == PATTERN_W - 1) && (b == PATTERN[0])) best = '0;
    return best;
  endfunction

  function automatic table_t build_tab_f();
    table_t t;
    t = '0;
    for (int k = 0; k < PATTERN_W; k++) begin
      t[2*k]     = next_k_f(k, 1'b0);
      t[2*k + 1] = next_k_f(k, 1'b1);
    end
    return t;
  endfunction

  localparam table_t NEXT_TAB = build_tab_f();

  state_t           state_r;
  state_t           state_nxt_s;
  logic             legal_s;
  logic             match_s;
  logic             match_q_r;
  logic [CNT_W-1:0] count_r;

  if (POW2) begin : g_full
    assign legal_s = 1'b1;
  end else begin : g_part
    assign legal_s = (state_r <= LAST);
  end

  // Next-state and Mealy match; clear discards the bit, illegal codes fall to S0.
  always_comb begin
    state_nxt_s = state_r;
    match_s     = 1'b0;
    if (clear) begin
      state_nxt_s = '0;
    end else if (!legal_s) begin
      state_nxt_s = '0;
    end else if (din_valid) begin
      state_nxt_s = NEXT_TAB[{state_r, din}];
      if ((state_r == LAST) && (din == PATTERN[0])) begin
        match_s = reset_n;
      end else begin
        match_s = 1'b0;
      end
    end else begin
      state_nxt_s = state_r;
    end
  end

  // State, registered match flag and saturating counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= '0;
      match_q_r <= 1'b0;
      count_r   <= '0;
    end else if (clear) begin
      state_r   <= '0;
      match_q_r <= 1'b0;
      count_r   <= '0;
    end else begin
      state_r   <= state_nxt_s;
      match_q_r <= match_s;
      if (match_s && (count_r != CNT_MAX)) begin
        count_r <= count_r + CNT_W'(1);
      end
    end
  end

  assign match       = match_s;
  assign match_q     = match_q_r;
  assign match_count = count_r;
  assign state_o     = state_r;

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param: three configurations share stimulus,
// expectations go through a scoreboard queue and are checked by assertions.
module tb_seq_detector_param;

  logic       clk;
  logic       reset_n;
  logic       clear;
  logic       din;
  logic       din_valid;

  logic       m0, mq0, m1, mq1, m2, mq2;
  logic [7:0] c0, c1;
  logic [1:0] c2;
  logic [1:0] k0, k1;
  logic [0:0] k2;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic m;
    int   k;
    int   c;
  } exp_t;

  exp_t sb[$];

  seq_detector_param u_ov (
    .clk(clk), .reset_n(reset_n), .clear(clear), .din(din), .din_valid(din_valid),
    .match(m0), .match_q(mq0), .match_count(c0), .state_o(k0)
  );

  seq_detector_param #(.OVERLAP(1'b0)) u_no (
    .clk(clk), .reset_n(reset_n), .clear(clear), .din(din), .din_valid(din_valid),
    .match(m1), .match_q(mq1), .match_count(c1), .state_o(k1)
  );

  seq_detector_param #(.PATTERN_W(2), .PATTERN(2'b11), .OVERLAP(1'b1), .CNT_W(2)) u_sat (
    .clk(clk), .reset_n(reset_n), .clear(clear), .din(din), .din_valid(din_valid),
    .match(m2), .match_q(mq2), .match_count(c2), .state_o(k2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] get_m(input int sel);
    case (sel)
      0:       return {31'b0, m0};
      1:       return {31'b0, m1};
      default: return {31'b0, m2};
    endcase
  endfunction

  function automatic logic [31:0] get_mq(input int sel);
    case (sel)
      0:       return {31'b0, mq0};
      1:       return {31'b0, mq1};
      default: return {31'b0, mq2};
    endcase
  endfunction

  function automatic logic [31:0] get_k(input int sel);
    case (sel)
      0:       return {30'b0, k0};
      1:       return {30'b0, k1};
      default: return {31'b0, k2};
    endcase
  endfunction

  function automatic logic [31:0] get_c(input int sel);
    case (sel)
      0:       return {24'b0, c0};
      1:       return {24'b0, c1};
      default: return {30'b0, c2};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // One bit: drive at negedge, check Mealy match before the edge, then state/count/match_q after it.
  task automatic step(input string tag, input int sel, input logic d, input logic v,
                      input logic c, input logic em, input int ek, input int ec);
    exp_t e;
    @(negedge clk);
    din       = d;
    din_valid = v;
    clear     = c;
    e.m = em;
    e.k = ek;
    e.c = ec;
    sb.push_back(e);
    #2;
    chk({tag, ".match"}, get_m(sel), {31'b0, sb[0].m});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({tag, ".state"},   get_k(sel),  e.k);
    chk({tag, ".count"},   get_c(sel),  e.c);
    chk({tag, ".match_q"}, get_mq(sel), {31'b0, e.m});
  endtask

  initial begin
    reset_n   = 1'b0;
    clear     = 1'b0;
    din       = 1'b0;
    din_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      chk("rst.state",   get_k(s),  32'd0);
      chk("rst.count",   get_c(s),  32'd0);
      chk("rst.match_q", get_mq(s), 32'd0);
      chk("rst.match",   get_m(s),  32'd0);
    end
    @(negedge clk);
    reset_n = 1'b1;

    // T1: overlapping, 1011 stream 1,0,1,1,0,1,1
    step("T1", 0, 1'b1, 1'b1, 1'b0, 1'b0, 1, 0);
    step("T1", 0, 1'b0, 1'b1, 1'b0, 1'b0, 2, 0);
    step("T1", 0, 1'b1, 1'b1, 1'b0, 1'b0, 3, 0);
    step("T1", 0, 1'b1, 1'b1, 1'b0, 1'b1, 1, 1);
    step("T1", 0, 1'b0, 1'b1, 1'b0, 1'b0, 2, 1);
    step("T1", 0, 1'b1, 1'b1, 1'b0, 1'b0, 3, 1);
    step("T1", 0, 1'b1, 1'b1, 1'b0, 1'b1, 1, 2);

    // T2: same stream, non-overlapping; state restarts at 0 after the match
    step("T2clr", 1, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0);
    step("T2", 1, 1'b1, 1'b1, 1'b0, 1'b0, 1, 0);
    step("T2", 1, 1'b0, 1'b1, 1'b0, 1'b0, 2, 0);
    step("T2", 1, 1'b1, 1'b1, 1'b0, 1'b0, 3, 0);
    step("T2", 1, 1'b1, 1'b1, 1'b0, 1'b1, 0, 1);
    step("T2", 1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1);
    step("T2", 1, 1'b1, 1'b1, 1'b0, 1'b0, 1, 1);
    step("T2", 1, 1'b1, 1'b1, 1'b0, 1'b0, 1, 1);

    // T3: fallback to a non-zero prefix, 1,0,1,0,1,0,1,1
    step("T3clr", 0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0);
    step("T3", 0, 1'b1, 1'b1, 1'b0, 1'b0, 1, 0);
    step("T3", 0, 1'b0, 1'b1, 1'b0, 1'b0, 2, 0);
    step("T3", 0, 1'b1, 1'b1, 1'b0, 1'b0, 3, 0);
    step("T3", 0, 1'b0, 1'b1, 1'b0, 1'b0, 2, 0);
    step("T3", 0, 1'b1, 1'b1, 1'b0, 1'b0, 3, 0);
    step("T3", 0, 1'b0, 1'b1, 1'b0, 1'b0, 2, 0);
    step("T3", 0, 1'b1, 1'b1, 1'b0, 1'b0, 3, 0);
    step("T3", 0, 1'b1, 1'b1, 1'b0, 1'b1, 1, 1);

    // T4: five invalid cycles inside a partial match, din toggling underneath
    step("T4clr", 0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
    step("T4", 0, 1'b1, 1'b1, 1'b0, 1'b0, 1, 0);
    step("T4", 0, 1'b0, 1'b1, 1'b0, 1'b0, 2, 0);
    for (int g = 0; g < 5; g++) begin
      step("T4gap", 0, g[0] ? 1'b0 : 1'b1, 1'b0, 1'b0, 1'b0, 2, 0);
    end
    step("T4", 0, 1'b1, 1'b1, 1'b0, 1'b0, 3, 0);
    step("T4", 0, 1'b1, 1'b1, 1'b0, 1'b1, 1, 1);

    // T5: partial match, then a match, then reset_n falls mid-cycle
    step("T5", 0, 1'b0, 1'b1, 1'b0, 1'b0, 2, 1);
    step("T5", 0, 1'b1, 1'b1, 1'b0, 1'b0, 3, 1);
    step("T5", 0, 1'b1, 1'b1, 1'b0, 1'b1, 1, 2);
    #2;
    reset_n = 1'b0;
    #1;
    chk("T5rst.state",   get_k(0),  32'd0);
    chk("T5rst.count",   get_c(0),  32'd0);
    chk("T5rst.match_q", get_mq(0), 32'd0);
    chk("T5rst.match",   get_m(0),  32'd0);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    step("T5post", 0, 1'b1, 1'b1, 1'b0, 1'b0, 1, 0);

    // T6: pattern 11, 2-bit counter saturates, then clear overrides a matching bit
    step("T6clr", 2, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
    step("T6", 2, 1'b1, 1'b1, 1'b0, 1'b0, 1, 0);
    step("T6", 2, 1'b1, 1'b1, 1'b0, 1'b1, 1, 1);
    step("T6", 2, 1'b1, 1'b1, 1'b0, 1'b1, 1, 2);
    step("T6", 2, 1'b1, 1'b1, 1'b0, 1'b1, 1, 3);
    step("T6", 2, 1'b1, 1'b1, 1'b0, 1'b1, 1, 3);
    step("T6", 2, 1'b1, 1'b1, 1'b0, 1'b1, 1, 3);
    step("T6", 2, 1'b1, 1'b1, 1'b0, 1'b1, 1, 3);
    step("T6clr", 2, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
